// File: rtl/sim_monitor_pkg.sv
// rtl/sim_monitor_pkg.sv - shared verdict codes and FSM state encodings for the exit monitor
// Purpose: constants shared by the exit monitor and its bench.
// Contents: verdict_t (NONE/PASS/FAIL/TIMEOUT as driven on verdict_o),
//           STATE_* encodings of the RUN -> DRAIN -> DONE sequence.
package sim_monitor_pkg;

    typedef enum logic [1:0] {
        VERDICT_NONE    = 2'd0,
        VERDICT_PASS    = 2'd1,
        VERDICT_FAIL    = 2'd2,
        VERDICT_TIMEOUT = 2'd3
    } verdict_t;

    localparam logic [1:0] STATE_RUN   = 2'd0;
    localparam logic [1:0] STATE_DRAIN = 2'd1;
    localparam logic [1:0] STATE_DONE  = 2'd2;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered head, no fall-through
// Purpose: buffers console bytes between the snooped bus and the drain stream.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset, discards contents
//   push       in   write request (accepted when not full, or when popping)
//   push_data  in   WIDTH data to write
//   pop        in   read request (ignored when empty)
//   full       out  DEPTH entries held
//   empty      out  no entries held
//   head_data  out  oldest entry, valid while !empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // One extra pointer bit tells a full ring from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the slot the write lands in.
    assign do_push = push && (!full || do_pop);

    assign head_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/sim_exit_monitor.sv
// rtl/sim_exit_monitor.sv - snoops dbus for exit/console writes and reports a final verdict
// Purpose: decodes exit writes (pass/fail), console byte writes (buffered and streamed out)
//          and a run timeout; raises done_o once the verdict is final and the console drained.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   dbus_cmd_addr_i      snooped address
//   dbus_cmd_we_i        snooped write strobe
//   dbus_write_data_i    snooped write data
//   cons_valid_o/cons_data_o/cons_ready_i   console byte stream
//   done_o               sticky, verdict final and console drained
//   verdict_o            0 none, 1 pass, 2 fail, 3 timeout
//   fail_data_o          data of the exit write
//   cycles_o             saturating cycles spent in RUN
//   overflow_o           sticky, a console byte was dropped
module sim_exit_monitor #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] EXIT_MASK  = 32'hF000_0000,
    parameter logic [ADDR_W-1:0] EXIT_BASE  = 32'h1000_0000,
    parameter logic [ADDR_W-1:0] CONS_MASK  = 32'hFFFF_FFFF,
    parameter logic [ADDR_W-1:0] CONS_BASE  = 32'h2000_0000,
    parameter logic [DATA_W-1:0] PASS_VALUE = 32'h777,
    parameter int                TIMEOUT    = 2500,
    parameter int                DRAIN_MAX  = 256,
    parameter int                FIFO_DEPTH = 16,
    parameter int                CNT_W      = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] dbus_cmd_addr_i,
    input  logic              dbus_cmd_we_i,
    input  logic [DATA_W-1:0] dbus_write_data_i,
    output logic              cons_valid_o,
    output logic [7:0]        cons_data_o,
    input  logic              cons_ready_i,
    output logic              done_o,
    output logic [1:0]        verdict_o,
    output logic [DATA_W-1:0] fail_data_o,
    output logic [CNT_W-1:0]  cycles_o,
    output logic              overflow_o
);

    import sim_monitor_pkg::*;

    localparam int                DRAIN_W      = $clog2(DRAIN_MAX + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST  = DRAIN_W'(DRAIN_MAX - 1);
    // Only meaningful when TIMEOUT != 0; the compare below is gated on that.
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]         state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               exit_hit;
    logic               cons_hit;
    logic               timeout_hit;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;

    // Exit decode wins over console decode for overlapping regions.
    assign exit_hit    = dbus_cmd_we_i && ((dbus_cmd_addr_i & EXIT_MASK) == EXIT_BASE);
    assign cons_hit    = dbus_cmd_we_i && ((dbus_cmd_addr_i & CONS_MASK) == CONS_BASE) && !exit_hit;
    assign timeout_hit = (TIMEOUT != 0) && (cycles_o == TIMEOUT_LAST);

    assign push         = cons_hit && (state == STATE_RUN);
    assign cons_valid_o = !fifo_empty;
    assign pop          = cons_valid_o && cons_ready_i;
    assign done_o       = (state == STATE_DONE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_cons_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push),
        .push_data (dbus_write_data_i[7:0]),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (cons_data_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= STATE_RUN;
            verdict_o   <= VERDICT_NONE;
            fail_data_o <= '0;
            cycles_o    <= '0;
            overflow_o  <= 1'b0;
            drain_cnt   <= '0;
        end else begin
            if (push && fifo_full && !pop) begin
                overflow_o <= 1'b1;
            end
            case (state)
                STATE_RUN: begin
                    if (cycles_o != '1) begin
                        cycles_o <= cycles_o + CNT_W'(1);
                    end
                    drain_cnt <= '0;
                    if (exit_hit) begin
                        fail_data_o <= dbus_write_data_i;
                        verdict_o   <= (dbus_write_data_i == PASS_VALUE) ? VERDICT_PASS : VERDICT_FAIL;
                        state       <= STATE_DRAIN;
                    end else if (timeout_hit) begin
                        verdict_o <= VERDICT_TIMEOUT;
                        state     <= STATE_DRAIN;
                    end
                end
                STATE_DRAIN: begin
                    if (fifo_empty || (drain_cnt == DRAIN_LAST)) begin
                        state <= STATE_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_exit_monitor.sv
// tb/tb_sim_exit_monitor.sv - directed self-checking bench for sim_exit_monitor
module tb_sim_exit_monitor;

    import sim_monitor_pkg::*;

    localparam int          DRAIN_MAX = 16;
    localparam logic [31:0] EXIT_ADDR = 32'h1000_0000;
    localparam logic [31:0] CONS_ADDR = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        cons_valid;
    logic [7:0]  cons_data;
    logic        cons_ready;
    logic        done;
    logic [1:0]  verdict;
    logic [31:0] fail_data;
    logic [63:0] cycles;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sim_exit_monitor #(
        .TIMEOUT    (100),
        .DRAIN_MAX  (DRAIN_MAX),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .dbus_cmd_addr_i   (addr),
        .dbus_cmd_we_i     (we),
        .dbus_write_data_i (wdata),
        .cons_valid_o      (cons_valid),
        .cons_data_o       (cons_data),
        .cons_ready_i      (cons_ready),
        .done_o            (done),
        .verdict_o         (verdict),
        .fail_data_o       (fail_data),
        .cycles_o          (cycles),
        .overflow_o        (overflow)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cycle(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        step();
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    task automatic do_reset(input logic rdy);
        rst        = 1'b1;
        we         = 1'b0;
        addr       = '0;
        wdata      = '0;
        cons_ready = rdy;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_verdict"},  64'(verdict),    64'(VERDICT_NONE));
        chk({tag, "_done"},     64'(done),       64'd0);
        chk({tag, "_faildata"}, 64'(fail_data),  64'd0);
        chk({tag, "_cycles"},   cycles,          64'd0);
        chk({tag, "_overflow"}, 64'(overflow),   64'd0);
        chk({tag, "_valid"},    64'(cons_valid), 64'd0);
    endtask

    logic [7:0] hi_bytes [3];
    logic [7:0] held     [5];

    initial begin
        hi_bytes = '{8'h48, 8'h69, 8'h0A};
        held     = '{8'h31, 8'h32, 8'h33, 8'h36, 8'h00};

        // Reset state
        do_reset(1'b0);
        chk_reset_state("reset");

        // 1: exit pass at cycle 50
        repeat (50) step();
        chk("t1_cycles_pre", cycles, 64'd50);
        write_cycle(EXIT_ADDR, 32'h777);
        chk("t1_verdict", 64'(verdict), 64'(VERDICT_PASS));
        chk("t1_done_early", 64'(done), 64'd0);
        chk("t1_cycles", cycles, 64'd51);
        chk("t1_faildata", 64'(fail_data), 64'h777);
        step();
        chk("t1_done", 64'(done), 64'd1);
        repeat (3) step();
        chk("t1_cycles_frozen", cycles, 64'd51);
        chk("t1_verdict_held", 64'(verdict), 64'(VERDICT_PASS));

        // 2: exit fail
        do_reset(1'b0);
        repeat (5) step();
        write_cycle(32'h1000_0004, 32'h0000_0BAD);
        chk("t2_verdict", 64'(verdict), 64'(VERDICT_FAIL));
        chk("t2_faildata", 64'(fail_data), 64'h0BAD);
        step();
        chk("t2_done", 64'(done), 64'd1);

        // 3: timeout
        do_reset(1'b0);
        repeat (99) step();
        chk("t3_cycles99", cycles, 64'd99);
        chk("t3_verdict_none", 64'(verdict), 64'(VERDICT_NONE));
        step();
        chk("t3_verdict", 64'(verdict), 64'(VERDICT_TIMEOUT));
        chk("t3_cycles100", cycles, 64'd100);
        chk("t3_done_early", 64'(done), 64'd0);
        step();
        chk("t3_done", 64'(done), 64'd1);
        repeat (5) step();
        chk("t3_cycles_frozen", cycles, 64'd100);

        // 4a: console bytes streamed with ready high, one at a time
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) begin
            write_cycle(CONS_ADDR, {24'h0, hi_bytes[i]});
            chk("t4a_valid", 64'(cons_valid), 64'd1);
            chk("t4a_data", 64'(cons_data), 64'(hi_bytes[i]));
            step();
            chk("t4a_popped", 64'(cons_valid), 64'd0);
        end
        write_cycle(EXIT_ADDR, 32'h777);
        chk("t4a_verdict", 64'(verdict), 64'(VERDICT_PASS));
        step();
        chk("t4a_done", 64'(done), 64'd1);

        // 4b: bytes buffered, drained after the exit; dbus ignored while draining
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            write_cycle(CONS_ADDR, {24'h0, hi_bytes[i]});
        end
        write_cycle(EXIT_ADDR, 32'h777);
        chk("t4b_verdict", 64'(verdict), 64'(VERDICT_PASS));
        chk("t4b_done0", 64'(done), 64'd0);
        chk("t4b_head0", 64'(cons_data), 64'h48);
        write_cycle(CONS_ADDR, 32'h55);
        chk("t4b_done1", 64'(done), 64'd0);
        cons_ready = 1'b1;
        write_cycle(EXIT_ADDR, 32'h0BAD);
        chk("t4b_head1", 64'(cons_data), 64'h69);
        chk("t4b_verdict_held", 64'(verdict), 64'(VERDICT_PASS));
        chk("t4b_faildata_held", 64'(fail_data), 64'h777);
        chk("t4b_done2", 64'(done), 64'd0);
        step();
        chk("t4b_head2", 64'(cons_data), 64'h0A);
        chk("t4b_done3", 64'(done), 64'd0);
        step();
        chk("t4b_empty", 64'(cons_valid), 64'd0);
        chk("t4b_done4", 64'(done), 64'd0);
        step();
        chk("t4b_done", 64'(done), 64'd1);

        // 5: overflow, full+pop, drain timeout
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            write_cycle(CONS_ADDR, 32'h30 + 32'(i));
        end
        chk("t5_ovf_at_full", 64'(overflow), 64'd0);
        chk("t5_head", 64'(cons_data), 64'h30);
        write_cycle(CONS_ADDR, 32'h34);
        chk("t5_ovf", 64'(overflow), 64'd1);
        write_cycle(CONS_ADDR, 32'h35);
        cons_ready = 1'b1;
        write_cycle(CONS_ADDR, 32'h36);
        cons_ready = 1'b0;
        chk("t5_fullpop_head", 64'(cons_data), 64'h31);
        chk("t5_ovf_sticky", 64'(overflow), 64'd1);
        write_cycle(EXIT_ADDR, 32'h777);
        repeat (DRAIN_MAX - 1) step();
        chk("t5_done_before_max", 64'(done), 64'd0);
        step();
        chk("t5_done_at_max", 64'(done), 64'd1);
        cons_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t5_drain_valid", 64'(cons_valid), 64'd1);
            chk("t5_drain_data", 64'(cons_data), 64'(held[i]));
            step();
        end
        chk("t5_drained", 64'(cons_valid), 64'd0);

        // 6: exit in the timeout cycle wins; reset mid-drain clears everything
        do_reset(1'b0);
        write_cycle(CONS_ADDR, 32'h41);
        write_cycle(CONS_ADDR, 32'h42);
        repeat (97) step();
        chk("t6_cycles99", cycles, 64'd99);
        write_cycle(EXIT_ADDR, 32'h777);
        chk("t6_verdict", 64'(verdict), 64'(VERDICT_PASS));
        chk("t6_valid_pre", 64'(cons_valid), 64'd1);
        chk("t6_done_pre", 64'(done), 64'd0);
        rst = 1'b1;
        step();
        chk_reset_state("t6_rst");
        rst = 1'b0;
        step();
        chk("t6_cycles_after", cycles, 64'd1);
        chk("t6_valid_after", 64'(cons_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
